load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, SHALL set the max cycles in REQ+WAIT before abort (range 1..65535).
REQ-002 One clock; reset is synchronous and active-high. Ports: clk_i  in  1  clock; rst_i  in  1  sync active-high reset.
REQ-003 x_valid_i  in  1  memory op present in X stage this cycle.
REQ-004 x_is_store_i  in  1  1=store, 0=load.
REQ-005 x_funct3_i  in  3  LOAD_B/H/W/BU/HU or STORE_B/H/W encoding.
REQ-006 x_addr_i  in  32  effective address (arith result); x_store_data_i  in  32  rs2 value.
REQ-007 m_flush_i  in  1  squash pending op.
REQ-008 dm_req_o  out  1; dm_we_o  out  1; dm_addr_o  out  32  word-aligned; dm_be_o  out  4; dm_wdata_o  out  32.
REQ-009 dm_gnt_i  in  1  request accepted; dm_rvalid_i  in  1  response/ack; dm_rdata_i  in  32.
REQ-010 stall_o  out  1  freeze pipeline; m_dm_dout_o  out  32  raw load word to writeback; misalign_o  out  1; bus_err_o  out  1.

Function
REQ-011 FSM states SHALL be IDLE, REQ, WAIT.
REQ-012 IDLE: x_valid_i=1 SHALL latch is_store, funct3, addr, steered data/be and move to REQ next edge; without x_valid_i, stay IDLE.
REQ-013 REQ: dm_req_o=1 with stable dm_* fields; dm_gnt_i=1 -> WAIT.
REQ-014 WAIT: dm_req_o=0; dm_rvalid_i=1 -> IDLE; loads capture dm_rdata_i into held register; stores treat rvalid as ack.
REQ-015 stall_o SHALL = (state==REQ) | (state==WAIT & ~dm_rvalid_i), so stall drops in the rvalid cycle.
REQ-016 m_dm_dout_o SHALL = dm_rdata_i when WAIT & dm_rvalid_i, else the held register (minimum load latency: 2 cycles after acceptance).
REQ-017 dm_addr_o = {addr[31:2],2'b00}; loads dm_be_o=4'b1111, dm_we_o=0.
REQ-018 SB: be=1<<addr[1:0], wdata=byte replicated x4; SH: be=addr[1]?1100:0011, wdata=half replicated x2; SW: be=1111, wdata as-is.
REQ-019 Timeout counter SHALL clear on entering REQ, increment each REQ/WAIT cycle; reaching TIMEOUT_CYC -> bus_err_o=1 for exactly one cycle, held data <= 0, IDLE, stall released same cycle.
REQ-020 m_flush_i in REQ with dm_gnt_i=0 SHALL abort to IDLE, dm_req_o low next cycle; gnt and flush together -> gnt wins, enter WAIT.
REQ-021 m_flush_i in WAIT SHALL be ignored; the response is absorbed, load data not captured.
REQ-022 dm_rvalid_i or dm_gnt_i in IDLE SHALL be ignored.

Reset
REQ-023 rst_i SHALL force IDLE; outputs dm_req_o, dm_we_o, stall_o, misalign_o, bus_err_o = 0; dm_addr_o, dm_be_o, dm_wdata_o, m_dm_dout_o = 0; counter = 0.
REQ-024 Reset mid-REQ/WAIT SHALL drop dm_req_o the following cycle; late responses fall under REQ-022.

Configuration
REQ-025 Macro LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL NOT issue a bus request; misalign_o pulses 1 cycle after x_valid_i, FSM stays IDLE, stall_o=0.
REQ-026 Macro undefined: misalign_o tied 0; offending low address bits treated as 0 for be/data steering and the access issues normally.

Structure
REQ-027 proc_pkg SHALL hold lsu_state_t enum and STORE_B/H/W funct3 constants beside existing LOAD_* encodings.
REQ-028 Combinational steering (be, wdata, misalign detect) SHALL live in sub-module lsu_store_align; FSM, counter, and registers stay in load_store_unit.

Verification
REQ-029 LW addr 0x100, gnt cycle 1, rvalid+rdata 0xDEADBEEF cycle 3 -> dm_addr_o=0x100, be=1111, stall high cycles 1-2, m_dm_dout_o=0xDEADBEEF cycle 3 and held after.
REQ-030 SB addr 0x203, data 0x000000A5 -> dm_addr_o=0x200, be=1000, wdata=0xA5A5A5A5, we=1.
REQ-031 SH addr 0x101: macro on -> misalign_o pulse, no dm_req_o; macro off -> be=0011, request issued.
REQ-032 TIMEOUT_CYC=4, gnt never asserted -> bus_err_o one-cycle pulse after 4 REQ cycles, m_dm_dout_o=0, FSM IDLE.
REQ-033 Flush in REQ with gnt=0 -> IDLE, no rvalid wait; flush with gnt=1 same cycle -> WAIT, response absorbed, data not captured.
REQ-034 rst_i asserted in WAIT, rvalid arrives 2 cycles later -> all outputs 0, response ignored, stall_o=0.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor encodings: load/store funct3 values, LSU state and the
// registered data-memory request bundle.
package proc_pkg;

    localparam logic [2:0] LOAD_B  = 3'b000;
    localparam logic [2:0] LOAD_H  = 3'b001;
    localparam logic [2:0] LOAD_W  = 3'b010;
    localparam logic [2:0] LOAD_BU = 3'b100;
    localparam logic [2:0] LOAD_HU = 3'b101;

    localparam logic [2:0] STORE_B = 3'b000;
    localparam logic [2:0] STORE_H = 3'b001;
    localparam logic [2:0] STORE_W = 3'b010;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } lsu_state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } dm_req_t;

    // Access size lives in the low two funct3 bits for both loads and stores.
    function automatic logic [1:0] access_size(input logic [2:0] funct3);
        return funct3[1:0];
    endfunction

endpackage

// File: rtl/lsu_store_align.sv
// Purpose: byte-enable / write-data steering and misalignment detect (LSU_MISALIGN_TRAP_EN).
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs are consumed when the LSU accepts an op.
module lsu_store_align
    import proc_pkg::*;
(
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misalign
);

    logic [1:0] off_eff;

    always_comb begin
        misalign = 1'b0;
        off_eff  = addr_lo;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = ((size == SIZE_H) && addr_lo[0]) ||
                   ((size == SIZE_W) && (addr_lo != 2'b00));
`endif
        // Offset bits that cannot apply to the access size are ignored.
        if (size == SIZE_H) begin
            off_eff = {addr_lo[1], 1'b0};
        end else if (size == SIZE_W) begin
            off_eff = 2'b00;
        end

        be    = 4'b1111;
        wdata = store_data;
        case (size)
            SIZE_B: begin
                be    = 4'b0001 << off_eff;
                wdata = {4{store_data[7:0]}};
            end
            SIZE_H: begin
                be    = off_eff[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase

        if (!is_store) begin
            be = 4'b1111;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Purpose: single-outstanding data-memory load/store FSM with timeout and flush (LSU_MISALIGN_TRAP_EN optional).
// Latency: request one cycle after accept; load data visible in the rvalid cycle, 2 cycles minimum.
// Backpressure: stall_o holds the pipeline through REQ and WAIT until rvalid, timeout or abort.
module load_store_unit
    import proc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        x_valid_i,
    input  logic        x_is_store_i,
    input  logic [2:0]  x_funct3_i,
    input  logic [31:0] x_addr_i,
    input  logic [31:0] x_store_data_i,
    input  logic        m_flush_i,
    output logic        dm_req_o,
    output logic        dm_we_o,
    output logic [31:0] dm_addr_o,
    output logic [3:0]  dm_be_o,
    output logic [31:0] dm_wdata_o,
    input  logic        dm_gnt_i,
    input  logic        dm_rvalid_i,
    input  logic [31:0] dm_rdata_i,
    output logic        stall_o,
    output logic [31:0] m_dm_dout_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    lsu_state_t  state_q;
    dm_req_t     req_q;
    logic        req_vld_q;
    logic        is_store_q;
    logic        squash_q;
    logic [15:0] cnt_q;
    logic [16:0] cnt_nxt;
    logic        timeout;
    logic [31:0] hold_q;
    logic        misalign_q;
    logic        bus_err_q;

    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic        al_misalign;
    logic        f3_sign_unused;

    // Sign/zero extension happens in writeback; only the size bits matter here.
    assign f3_sign_unused = x_funct3_i[2];

    lsu_store_align u_align (
        .is_store   (x_is_store_i),
        .size       (access_size(x_funct3_i)),
        .addr_lo    (x_addr_i[1:0]),
        .store_data (x_store_data_i),
        .be         (al_be),
        .wdata      (al_wdata),
        .misalign   (al_misalign)
    );

    assign cnt_nxt = {1'b0, cnt_q} + 17'd1;
    assign timeout = (cnt_nxt >= 17'(TIMEOUT_CYC));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            req_q      <= '0;
            req_vld_q  <= 1'b0;
            is_store_q <= 1'b0;
            squash_q   <= 1'b0;
            cnt_q      <= '0;
            hold_q     <= '0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (x_valid_i) begin
                        if (al_misalign) begin
                            misalign_q <= 1'b1;
                        end else begin
                            state_q     <= REQ;
                            req_vld_q   <= 1'b1;
                            req_q.we    <= x_is_store_i;
                            req_q.addr  <= {x_addr_i[31:2], 2'b00};
                            req_q.be    <= al_be;
                            req_q.wdata <= al_wdata;
                            is_store_q  <= x_is_store_i;
                            squash_q    <= 1'b0;
                            cnt_q       <= '0;
                        end
                    end
                end
                REQ: begin
                    cnt_q <= cnt_nxt[15:0];
                    // A grant commits the access even if a flush arrives with it.
                    if (dm_gnt_i) begin
                        state_q   <= WAIT;
                        req_vld_q <= 1'b0;
                        if (m_flush_i) begin
                            squash_q <= 1'b1;
                        end
                    end else if (m_flush_i) begin
                        state_q   <= IDLE;
                        req_vld_q <= 1'b0;
                    end else if (timeout) begin
                        state_q   <= IDLE;
                        req_vld_q <= 1'b0;
                        bus_err_q <= 1'b1;
                        hold_q    <= '0;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_nxt[15:0];
                    if (dm_rvalid_i) begin
                        state_q <= IDLE;
                        if (!is_store_q && !squash_q && !m_flush_i) begin
                            hold_q <= dm_rdata_i;
                        end
                    end else if (timeout) begin
                        state_q   <= IDLE;
                        bus_err_q <= 1'b1;
                        hold_q    <= '0;
                    end else if (m_flush_i) begin
                        squash_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    req_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign dm_req_o    = req_vld_q;
    assign dm_we_o     = req_q.we;
    assign dm_addr_o   = req_q.addr;
    assign dm_be_o     = req_q.be;
    assign dm_wdata_o  = req_q.wdata;
    assign misalign_o  = misalign_q;
    assign bus_err_o   = bus_err_q;

    assign stall_o     = (state_q == REQ) || ((state_q == WAIT) && !dm_rvalid_i);
    assign m_dm_dout_o = ((state_q == WAIT) && dm_rvalid_i) ? dm_rdata_i : hold_q;

endmodule
